adder_axis_arbiter: RTL and testbench

Round-robin arbiter that shares one `adder_axis_pipe` instance between NUM_REQ independent requesters. Each requester presents an operand pair on its own AXI-Stream slave port. The arbiter issues the granted pair to the adder's two operand streams, records the requester ID in an in-order tag FIFO, and routes each adder result back to the requester that issued it. It sits between the client blocks and the shared adder.

---
 rtl/adder_arb_pkg.sv | 34 +++
 rtl/adder_axis_arbiter_if.sv | 14 +
 rtl/arb_tag_fifo.sv | 60 ++++++
 rtl/adder_axis_arbiter.sv | 125 ++++++++++++
 tb/tb_adder_axis_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package adder_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Requester IDs are sized for the largest supported requester count.
    localparam int unsigned REQ_MAX = 8;
    localparam int unsigned ID_W    = $clog2(REQ_MAX);

    // First valid requester at or after ptr, searching upward and wrapping at num_req.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [REQ_MAX-1:0] valid,
        input logic [ID_W-1:0]    ptr,
        input int unsigned        num_req
    );
        logic [ID_W-1:0] win;
        logic            found;
        int unsigned     idx;
        win   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < REQ_MAX; k++) begin
            idx = (32'(ptr) + k) % num_req;
            if (k < num_req && !found && valid[ID_W'(idx)]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/adder_axis_arbiter_if.sv
// Generic AXI-Stream bundle; VALID_W > 1 carries per-requester valid/ready lanes.
interface adder_axis_arbiter_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned VALID_W = 1
) ();

    logic [DATA_W-1:0]  tdata;
    logic [VALID_W-1:0] tvalid;
    logic [VALID_W-1:0] tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);

endinterface

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every operand pair in flight.
module arb_tag_fifo
    import adder_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = ID_W
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/adder_axis_arbiter.sv
// Round-robin arbiter sharing one two-operand AXI-Stream adder among NUM_REQ requesters;
// results are steered back to their issuer through an in-order tag FIFO.
module adder_axis_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    adder_axis_arbiter_if.slave  req,
    adder_axis_arbiter_if.master add1,
    adder_axis_arbiter_if.master add2,
    adder_axis_arbiter_if.slave  res,
    adder_axis_arbiter_if.master rsp,
    output logic                 err_o
);

    localparam int unsigned PAIR_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    state_e              state_q, state_d;
    logic                p1_q, p1_d, p2_q, p2_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                err_q, err_d;

    logic [ID_W-1:0]     winner_c;
    logic [PAIR_W-1:0]   pair_c;
    logic                grant_c;
    logic                pop_c;
    logic [ID_W-1:0]     tag;
    logic [NUM_REQ-1:0]  tag_sel_c;
    logic                tag_full, tag_empty;
    logic [CNT_W-1:0]    tag_count;

    // Grant uses the registered tag count; a pop in this cycle only helps next cycle.
    always_comb begin
        winner_c = rr_pick(REQ_MAX'(req.tvalid), rr_ptr_q, NUM_REQ);
        pair_c   = req.tdata[32'(winner_c) * PAIR_W +: PAIR_W];
        grant_c  = !aresetn && (state_q == IDLE) && (|req.tvalid) && !tag_full
                   && (32'(tag_count) < MAX_OUTSTANDING);
    end

    assign req.tready = grant_c ? (NUM_REQ'(1) << winner_c) : '0;

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        a_d      = a_q;
        b_d      = b_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q || (res.tvalid && tag_empty);
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    a_d      = pair_c[WIDTH-1:0];
                    b_d      = pair_c[PAIR_W-1:WIDTH];
                    p1_d     = 1'b1;
                    p2_d     = 1'b1;
                    rr_ptr_d = (32'(winner_c) + 32'd1 == NUM_REQ) ? '0 : winner_c + ID_W'(1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Each operand side retires on its own handshake, in any order.
                if (add1.tready) p1_d = 1'b0;
                if (add2.tready) p2_d = 1'b0;
                if (!p1_d && !p2_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_q  <= IDLE;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign add1.tdata  = a_q;
    assign add1.tvalid = p1_q;
    assign add2.tdata  = b_q;
    assign add2.tvalid = p2_q;
    assign err_o       = err_q;

    // Response steering: head tag selects the single requester that sees this result.
    assign tag_sel_c  = NUM_REQ'(1) << tag;
    assign res.tready = !tag_empty && (|(rsp.tready & tag_sel_c));
    assign rsp.tvalid = (res.tvalid && !tag_empty) ? tag_sel_c : '0;
    assign rsp.tdata  = res.tdata;
    assign pop_c      = res.tvalid && res.tready;

    arb_tag_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .DATA_W (ID_W)
    ) u_tag_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (grant_c),
        .wr_data (winner_c),
        .pop     (pop_c),
        .rd_data (tag),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

endmodule

// File: tb/tb_adder_axis_arbiter.sv
// Directed bench for adder_axis_arbiter with a behavioural in-order adder on the shared port.
module tb_adder_axis_arbiter;

    logic aclk;
    logic aresetn;
    logic err_o;

    adder_axis_arbiter_if #(.DATA_W(64), .VALID_W(4)) req_if ();
    adder_axis_arbiter_if #(.DATA_W(8),  .VALID_W(1)) add1_if ();
    adder_axis_arbiter_if #(.DATA_W(8),  .VALID_W(1)) add2_if ();
    adder_axis_arbiter_if #(.DATA_W(9),  .VALID_W(1)) res_if ();
    adder_axis_arbiter_if #(.DATA_W(9),  .VALID_W(4)) rsp_if ();

    adder_axis_arbiter #(
        .NUM_REQ         (4),
        .WIDTH           (8),
        .MAX_OUTSTANDING (4)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (req_if),
        .add1    (add1_if),
        .add2    (add2_if),
        .res     (res_if),
        .rsp     (rsp_if),
        .err_o   (err_o)
    );

    int errors = 0;
    int checks = 0;

    int         grant_log[$];
    int         rsp_id_q[$];
    logic [8:0] rsp_dat_q[$];
    logic [8:0] sum_q[$];
    logic [7:0] m_a, m_b;
    bit         m_ha = 1'b0;
    bit         m_hb = 1'b0;
    bit         res_force = 1'b0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Adder model: drives res at negedge, observes handshakes just before the posedge.
    always @(negedge aclk) begin
        res_if.tvalid = 1'(res_force || (sum_q.size() > 0));
        res_if.tdata  = (sum_q.size() > 0) ? sum_q[0] : 9'h000;
        #4;
        if (aresetn) begin
            sum_q.delete();
            m_ha = 1'b0;
            m_hb = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_if.tvalid[i] && req_if.tready[i]) grant_log.push_back(i);
                if (rsp_if.tvalid[i] && rsp_if.tready[i]) begin
                    rsp_id_q.push_back(i);
                    rsp_dat_q.push_back(rsp_if.tdata);
                end
            end
            if (res_if.tvalid[0] && res_if.tready[0] && sum_q.size() > 0) void'(sum_q.pop_front());
            if (add1_if.tvalid[0] && add1_if.tready[0]) begin m_a = add1_if.tdata; m_ha = 1'b1; end
            if (add2_if.tvalid[0] && add2_if.tready[0]) begin m_b = add2_if.tdata; m_hb = 1'b1; end
            if (m_ha && m_hb) begin
                sum_q.push_back(9'(m_a) + 9'(m_b));
                m_ha = 1'b0;
                m_hb = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic set_pair(input int i, input logic [7:0] b, input logic [7:0] a);
        req_if.tdata[i*16 +: 16] = {b, a};
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rsp_id_q.delete();
        rsp_dat_q.delete();
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        req_if.tvalid = 4'hF;
        step();
        step();
        checks++; if (req_if.tready !== 4'h0) begin errors++; $display("FAIL reset_req_tready got=%h exp=0", req_if.tready); end
        checks++; if (add1_if.tvalid !== 1'b0 || add2_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_add_tvalid got=%b%b exp=00", add1_if.tvalid, add2_if.tvalid); end
        checks++; if (add1_if.tdata !== 8'h00 || add2_if.tdata !== 8'h00) begin errors++; $display("FAIL reset_add_tdata got=%h/%h exp=00/00", add1_if.tdata, add2_if.tdata); end
        checks++; if (res_if.tready !== 1'b0) begin errors++; $display("FAIL reset_res_tready got=%b exp=0", res_if.tready); end
        checks++; if (rsp_if.tvalid !== 4'h0) begin errors++; $display("FAIL reset_rsp_tvalid got=%h exp=0", rsp_if.tvalid); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
        req_if.tvalid = 4'h0;
        aresetn = 1'b0;
        step();
    endtask

    task automatic test_single();
        clear_logs();
        set_pair(2, 8'h05, 8'h03);
        req_if.tvalid = 4'b0100;
        #1;
        checks++; if (req_if.tready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_if.tready); end
        step();
        req_if.tvalid = 4'h0;
        checks++; if (add1_if.tvalid !== 1'b1 || add2_if.tvalid !== 1'b1) begin errors++; $display("FAIL single_add_valid got=%b%b exp=11", add1_if.tvalid, add2_if.tvalid); end
        checks++; if (add1_if.tdata !== 8'h03) begin errors++; $display("FAIL single_add1 got=%h exp=03", add1_if.tdata); end
        checks++; if (add2_if.tdata !== 8'h05) begin errors++; $display("FAIL single_add2 got=%h exp=05", add2_if.tdata); end
        step();
        checks++; if (rsp_if.tvalid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0100", rsp_if.tvalid); end
        checks++; if (rsp_if.tdata !== 9'h008) begin errors++; $display("FAIL single_rsp_data got=%h exp=008", rsp_if.tdata); end
        step();
        checks++; if (rsp_if.tvalid !== 4'h0) begin errors++; $display("FAIL single_rsp_done got=%b exp=0000", rsp_if.tvalid); end
    endtask

    task automatic test_round_robin();
        int         exp_g[5] = '{0, 1, 2, 3, 0};
        logic [8:0] exp_d[5] = '{9'h003, 9'h030, 9'h100, 9'h1FE, 9'h003};
        aresetn = 1'b1;
        step();
        aresetn = 1'b0;
        clear_logs();
        set_pair(0, 8'h01, 8'h02);
        set_pair(1, 8'h10, 8'h20);
        set_pair(2, 8'h7F, 8'h81);
        set_pair(3, 8'hFF, 8'hFF);
        req_if.tvalid = 4'hF;
        for (int n = 0; n < 40 && grant_log.size() < 5; n++) step();
        req_if.tvalid = 4'h0;
        repeat (10) step();
        checks++; if (grant_log.size() != 5) begin errors++; $display("FAIL rr_grant_count got=%0d exp=5", grant_log.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= grant_log.size() || grant_log[i] != exp_g[i]) begin
                errors++; $display("FAIL rr_grant_order[%0d] got=%0d exp=%0d", i, (i < grant_log.size()) ? grant_log[i] : -1, exp_g[i]);
            end
            checks++;
            if (i >= rsp_id_q.size() || rsp_id_q[i] != exp_g[i] || rsp_dat_q[i] !== exp_d[i]) begin
                errors++; $display("FAIL rr_rsp[%0d] got=%0d/%h exp=%0d/%h", i, (i < rsp_id_q.size()) ? rsp_id_q[i] : -1,
                                   (i < rsp_dat_q.size()) ? rsp_dat_q[i] : 9'h000, exp_g[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        rsp_if.tready = 4'h0;
        set_pair(0, 8'h01, 8'h01);
        req_if.tvalid = 4'b0001;
        repeat (20) step();
        checks++; if (grant_log.size() != 4) begin errors++; $display("FAIL bp_outstanding got=%0d exp=4", grant_log.size()); end
        checks++; if (rsp_if.tvalid !== 4'b0001) begin errors++; $display("FAIL bp_rsp_valid got=%b exp=0001", rsp_if.tvalid); end
        checks++; if (res_if.tready !== 1'b0) begin errors++; $display("FAIL bp_res_tready got=%b exp=0", res_if.tready); end
        rsp_if.tready = 4'hF;
        #1;
        checks++; if (req_if.tready !== 4'h0) begin errors++; $display("FAIL bp_pop_cycle_grant got=%b exp=0000", req_if.tready); end
        step();
        checks++; if (req_if.tready !== 4'b0001) begin errors++; $display("FAIL bp_after_pop_grant got=%b exp=0001", req_if.tready); end
        step();
        req_if.tvalid = 4'h0;
        repeat (12) step();
        checks++; if (grant_log.size() != 5 || rsp_id_q.size() != 5) begin errors++; $display("FAIL bp_totals got=%0d/%0d exp=5/5", grant_log.size(), rsp_id_q.size()); end
        for (int i = 0; i < rsp_id_q.size(); i++) begin
            checks++;
            if (rsp_id_q[i] != 0 || rsp_dat_q[i] !== 9'h002) begin errors++; $display("FAIL bp_rsp[%0d] got=%0d/%h exp=0/002", i, rsp_id_q[i], rsp_dat_q[i]); end
        end
    endtask

    task automatic test_split_handshake();
        clear_logs();
        add1_if.tready = 1'b0;
        add2_if.tready = 1'b0;
        set_pair(1, 8'h22, 8'h11);
        set_pair(3, 8'h40, 8'h02);
        req_if.tvalid = 4'b0010;
        #1;
        checks++; if (req_if.tready !== 4'b0010) begin errors++; $display("FAIL split_grant got=%b exp=0010", req_if.tready); end
        step();
        req_if.tvalid = 4'b1000;
        add2_if.tready = 1'b1;
        #1;
        checks++; if (req_if.tready !== 4'h0) begin errors++; $display("FAIL split_issue_ready got=%b exp=0000", req_if.tready); end
        checks++; if (add2_if.tdata !== 8'h22) begin errors++; $display("FAIL split_add2_data got=%h exp=22", add2_if.tdata); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (add2_if.tvalid !== 1'b0 || add1_if.tvalid !== 1'b1 || add1_if.tdata !== 8'h11 || req_if.tready !== 4'h0) begin
                errors++; $display("FAIL split_pending[%0d] got=v2:%b v1:%b d1:%h rdy:%b exp=v2:0 v1:1 d1:11 rdy:0000",
                                   k, add2_if.tvalid, add1_if.tvalid, add1_if.tdata, req_if.tready);
            end
        end
        add1_if.tready = 1'b1;
        step();
        checks++; if (add1_if.tvalid !== 1'b0 || req_if.tready !== 4'b1000) begin errors++; $display("FAIL split_back_idle got=v1:%b rdy:%b exp=v1:0 rdy:1000", add1_if.tvalid, req_if.tready); end
        step();
        req_if.tvalid = 4'h0;
        repeat (8) step();
        checks++;
        if (rsp_id_q.size() != 2 || rsp_id_q[0] != 1 || rsp_dat_q[0] !== 9'h033 || rsp_id_q[1] != 3 || rsp_dat_q[1] !== 9'h042) begin
            errors++; $display("FAIL split_rsp got=n%0d %0d/%h %0d/%h exp=n2 1/033 3/042", rsp_id_q.size(),
                               (rsp_id_q.size() > 0) ? rsp_id_q[0] : -1, (rsp_dat_q.size() > 0) ? rsp_dat_q[0] : 9'h000,
                               (rsp_id_q.size() > 1) ? rsp_id_q[1] : -1, (rsp_dat_q.size() > 1) ? rsp_dat_q[1] : 9'h000);
        end
    endtask

    task automatic test_err();
        res_force = 1'b1;
        step();
        checks++; if (res_if.tready !== 1'b0 || rsp_if.tvalid !== 4'h0) begin errors++; $display("FAIL err_no_rsp got=rdy:%b v:%b exp=rdy:0 v:0000", res_if.tready, rsp_if.tvalid); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_before_edge got=%b exp=0", err_o); end
        res_force = 1'b0;
        step();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err_o); end
        step();
        step();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err_o); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        rsp_if.tready = 4'h0;
        set_pair(0, 8'h01, 8'h02);
        set_pair(1, 8'h01, 8'h01);
        req_if.tvalid = 4'b0011;
        for (int n = 0; n < 20 && grant_log.size() < 2; n++) step();
        checks++; if (grant_log.size() != 2 || add1_if.tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_setup got=n%0d v1:%b exp=n2 v1:1", grant_log.size(), add1_if.tvalid); end
        aresetn = 1'b1;
        req_if.tvalid = 4'b1000;
        step();
        checks++; if (req_if.tready !== 4'h0 || res_if.tready !== 1'b0 || rsp_if.tvalid !== 4'h0) begin errors++; $display("FAIL rstmid_handshake got=%b/%b/%b exp=0000/0/0000", req_if.tready, res_if.tready, rsp_if.tvalid); end
        checks++; if (add1_if.tvalid !== 1'b0 || add2_if.tvalid !== 1'b0 || add1_if.tdata !== 8'h00 || add2_if.tdata !== 8'h00) begin
            errors++; $display("FAIL rstmid_add got=%b%b %h/%h exp=00 00/00", add1_if.tvalid, add2_if.tvalid, add1_if.tdata, add2_if.tdata);
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", err_o); end
        aresetn = 1'b0;
        rsp_if.tready = 4'hF;
        clear_logs();
        set_pair(3, 8'h0A, 8'h14);
        req_if.tvalid = 4'b1001;
        #1;
        checks++; if (req_if.tready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got=%b exp=0001", req_if.tready); end
        step();
        req_if.tvalid = 4'b1000;
        for (int n = 0; n < 20 && grant_log.size() < 2; n++) step();
        req_if.tvalid = 4'h0;
        repeat (8) step();
        checks++;
        if (rsp_id_q.size() != 2 || rsp_id_q[0] != 0 || rsp_dat_q[0] !== 9'h003 || rsp_id_q[1] != 3 || rsp_dat_q[1] !== 9'h01E) begin
            errors++; $display("FAIL rstmid_rsp got=n%0d %0d/%h %0d/%h exp=n2 0/003 3/01e", rsp_id_q.size(),
                               (rsp_id_q.size() > 0) ? rsp_id_q[0] : -1, (rsp_dat_q.size() > 0) ? rsp_dat_q[0] : 9'h000,
                               (rsp_id_q.size() > 1) ? rsp_id_q[1] : -1, (rsp_dat_q.size() > 1) ? rsp_dat_q[1] : 9'h000);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn        = 1'b1;
        req_if.tdata   = '0;
        req_if.tvalid  = 4'h0;
        add1_if.tready = 1'b1;
        add2_if.tready = 1'b1;
        rsp_if.tready  = 4'hF;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_split_handshake();
        test_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
